// File: rtl/jedro_1_defines.sv
// Shared jedro_1 bus definitions: data width and the data-bus response word.
package jedro_1_defines;

  localparam int DATA_WIDTH = 32;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic                  error;
  } data_rsp_t;

endpackage

// File: rtl/jedro_1_ram_sp.sv
// Word-wide single-port RAM with per-byte write enables and a registered read port.
module jedro_1_ram_sp
  import jedro_1_defines::*;
#(
  parameter int MEM_WORDS = 1024,
  parameter     INIT_FILE = "",
  localparam int AW = $clog2(MEM_WORDS)
) (
  input  logic                  clk,
  input  logic                  en,
  input  logic [3:0]            we,
  input  logic [AW-1:0]         addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [MEM_WORDS];

  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (we[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
    end
    if (en) rdata <= mem[addr];
  end

endmodule

// File: rtl/jedro_1_data_ram.sv
// jedro_1 data-bus responder: decode, one in-flight stage, response FIFO, credit-based ready.
module jedro_1_data_ram
  import jedro_1_defines::*;
#(
  parameter int          MEM_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          RSP_DEPTH = 3,
  parameter              INIT_FILE = ""
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [DATA_WIDTH-1:0] data_req_addr_i,
  input  logic [DATA_WIDTH-1:0] data_req_data_i,
  input  logic [3:0]            data_req_strobe_i,
  input  logic                  data_req_write_i,
  input  logic                  data_req_valid_i,
  output logic                  data_req_ready_o,
  output logic [DATA_WIDTH-1:0] data_rsp_data_o,
  output logic                  data_rsp_error_o,
  output logic                  data_rsp_valid_o,
  input  logic                  data_rsp_ready_i
);

  localparam int          AW   = $clog2(MEM_WORDS);
  localparam int          PW   = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam int          CW   = $clog2(RSP_DEPTH + 1);
  localparam logic [32:0] SPAN = 33'(MEM_WORDS) * 33'd4;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(RSP_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  logic [31:0]           offset;
  logic                  in_range;
  logic                  req_fire;
  logic [3:0]            ram_we;
  logic                  ram_en;
  logic [DATA_WIDTH-1:0] ram_rdata;
  logic                  unused_bits;

  assign offset      = data_req_addr_i - BASE_ADDR;
  assign in_range    = {1'b0, offset} < SPAN;
  assign req_fire    = data_req_valid_i & data_req_ready_o;
  assign ram_we      = (req_fire && data_req_write_i && in_range) ? data_req_strobe_i : 4'b0000;
  assign ram_en      = req_fire & ~data_req_write_i & in_range;
  assign unused_bits = ^offset[1:0];

  jedro_1_ram_sp #(
    .MEM_WORDS (MEM_WORDS),
    .INIT_FILE (INIT_FILE)
  ) u_ram (
    .clk   (clk_i),
    .en    (ram_en),
    .we    (ram_we),
    .addr  (offset[AW+1:2]),
    .wdata (data_req_data_i),
    .rdata (ram_rdata)
  );

  // In-flight stage: the RAM read data is only valid the cycle after fire.
  logic infl_q, infl_rd_q, infl_err_q;

  data_rsp_t         fifo_q [RSP_DEPTH];
  data_rsp_t         push_rsp;
  logic [PW-1:0]     wptr_q, rptr_q;
  logic [CW-1:0]     count_q, count_next;
  logic [CW:0]       occ_next;
  logic              push, pop;

  assign push          = infl_q;
  assign pop           = data_rsp_valid_o & data_rsp_ready_i;
  assign push_rsp.data = infl_rd_q ? ram_rdata : '0;
  assign push_rsp.error = infl_err_q;
  assign count_next    = count_q + CW'(push) - CW'(pop);
  assign occ_next      = {1'b0, count_next} + (CW+1)'(req_fire);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      infl_q           <= 1'b0;
      infl_rd_q        <= 1'b0;
      infl_err_q       <= 1'b0;
      wptr_q           <= '0;
      rptr_q           <= '0;
      count_q          <= '0;
      data_req_ready_o <= 1'b0;
    end else begin
      infl_q           <= req_fire;
      infl_rd_q        <= req_fire & ~data_req_write_i & in_range;
      infl_err_q       <= req_fire & ~in_range;
      if (push) wptr_q <= ptr_inc(wptr_q);
      if (pop)  rptr_q <= ptr_inc(rptr_q);
      count_q          <= count_next;
      data_req_ready_o <= occ_next < (CW+1)'(RSP_DEPTH);
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) fifo_q[wptr_q] <= push_rsp;
  end

  // Outputs come from registered state only; gated so reset leaves them at zero.
  assign data_rsp_valid_o = (count_q != '0);
  assign data_rsp_data_o  = data_rsp_valid_o ? fifo_q[rptr_q].data : '0;
  assign data_rsp_error_o = data_rsp_valid_o & fifo_q[rptr_q].error;

endmodule

// File: tb/tb_jedro_1_data_ram.sv
// Randomized scoreboard bench for jedro_1_data_ram against a word-array memory model.
module tb_jedro_1_data_ram;
  import jedro_1_defines::*;

  localparam int MW = 1024;
  localparam int NW = 64;
  localparam logic [31:0] BASE = 32'h0000_0000;

  logic        clk = 0, rst = 1;
  logic [31:0] req_addr = 0, req_data = 0;
  logic [3:0]  req_strobe = 0;
  logic        req_write = 0, req_valid = 0, req_ready;
  logic [31:0] rsp_data;
  logic        rsp_error, rsp_valid, rsp_ready = 1;

  logic        d2_valid = 0, d2_ready, d2_rsp_valid, d2_rsp_error;
  logic [31:0] d2_rsp_data;

  always #5 clk = ~clk;

  jedro_1_data_ram #(.MEM_WORDS(MW), .BASE_ADDR(BASE), .RSP_DEPTH(3), .INIT_FILE("")) dut (
    .clk_i(clk), .rst_i(rst),
    .data_req_addr_i(req_addr), .data_req_data_i(req_data), .data_req_strobe_i(req_strobe),
    .data_req_write_i(req_write), .data_req_valid_i(req_valid), .data_req_ready_o(req_ready),
    .data_rsp_data_o(rsp_data), .data_rsp_error_o(rsp_error), .data_rsp_valid_o(rsp_valid),
    .data_rsp_ready_i(rsp_ready));

  jedro_1_data_ram #(.MEM_WORDS(16), .BASE_ADDR(BASE), .RSP_DEPTH(2), .INIT_FILE("")) dut2 (
    .clk_i(clk), .rst_i(rst),
    .data_req_addr_i(32'h0), .data_req_data_i(32'h0), .data_req_strobe_i(4'h0),
    .data_req_write_i(1'b0), .data_req_valid_i(d2_valid), .data_req_ready_o(d2_ready),
    .data_rsp_data_o(d2_rsp_data), .data_rsp_error_o(d2_rsp_error), .data_rsp_valid_o(d2_rsp_valid),
    .data_rsp_ready_i(1'b1));

  int          n_cmp = 0, n_bad = 0;
  int          cyc = 0, fire_cyc = 0, d2_rsp_n = 0;
  logic [31:0] model [NW];
  data_rsp_t   exp_q [$];
  int          rsp_cyc [$];
  logic        hold_v = 0, hold_e = 0;
  logic [31:0] hold_d = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard whenever a response is handed over.
  always @(negedge clk) begin
    data_rsp_t e;
    if (rst) hold_v = 0;
    else begin
      if (hold_v) begin
        check("hold_valid", 32'(rsp_valid), 32'd1);
        check("hold_data", rsp_data, hold_d);
        check("hold_error", 32'(rsp_error), 32'(hold_e));
      end
      hold_v = 0;
      if (rsp_valid && rsp_ready) begin
        rsp_cyc.push_back(cyc);
        if (exp_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_rsp: got data %h err %b want none", rsp_data, rsp_error);
        end else begin
          e = exp_q.pop_front();
          check("rsp_data", rsp_data, e.data);
          check("rsp_error", 32'(rsp_error), 32'(e.error));
        end
      end else if (rsp_valid) begin
        hold_v = 1; hold_d = rsp_data; hold_e = rsp_error;
      end
    end
    if (!rst && d2_rsp_valid) d2_rsp_n++;
  end

  task automatic model_fire(input logic [31:0] a, d, input logic [3:0] s, input bit w);
    logic [31:0] off;
    int          idx;
    data_rsp_t   r;
    off = a - BASE;
    idx = int'(off >> 2);
    r.data = '0; r.error = 1'b0;
    if (off >= 32'(MW * 4)) r.error = 1'b1;
    else if (w) begin
      for (int b = 0; b < 4; b++) if (s[b]) model[idx][8*b +: 8] = d[8*b +: 8];
    end else r.data = model[idx];
    exp_q.push_back(r);
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic issue(input logic [31:0] a, d, input logic [3:0] s, input bit w, output bit ok);
    req_addr = a; req_data = d; req_strobe = s; req_write = w; req_valid = 1;
    @(negedge clk);
    ok = req_ready;
    if (ok) begin model_fire(a, d, s, w); fire_cyc = cyc; end
    @(posedge clk); #1;
    req_valid = 0;
  endtask

  task automatic send(input logic [31:0] a, d, input logic [3:0] s, input bit w);
    bit ok = 0;
    int n = 0;
    while (!ok && n < 100) begin issue(a, d, s, w, ok); n++; end
    if (!ok) begin n_cmp++; n_bad++; $display("FAIL send_timeout: addr %h not accepted", a); end
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 300) begin tick(); n++; end
    check("drain", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit ok;
    int k, n_ok, first_fire, acc, streak, maxs;
    bit rnd_done;
    logic [31:0] a;

    repeat (3) tick();
    @(negedge clk);
    check("rst_ready", 32'(req_ready), 0);
    check("rst_valid", 32'(rsp_valid), 0);
    check("rst_data", rsp_data, 0);
    check("rst_error", 32'(rsp_error), 0);
    @(posedge clk); #1;
    rst = 0;
    tick();
    check("first_ready", 32'(req_ready), 1);

    for (int i = 0; i < NW; i++) send(32'(i * 4), $urandom, 4'hF, 1);
    drain();

    // write then read, plus latency from an idle FIFO
    send(32'h10, 32'hDEAD_BEEF, 4'hF, 1);
    drain();
    send(32'h10, 32'h0, 4'h0, 0);
    drain();
    check("latency", 32'(rsp_cyc[rsp_cyc.size()-1] - fire_cyc), 32'd2);

    send(32'h20, 32'h1122_3344, 4'hF, 1);
    send(32'h20, 32'hAABB_CCDD, 4'b0101, 1);
    send(32'h20, 32'h0, 4'h0, 0);
    send(32'h08, 32'hFFFF_FFFF, 4'h0, 1);
    send(32'h08, 32'h0, 4'h0, 0);
    send(32'(MW * 4), 32'h0, 4'h0, 0);
    send(32'(MW * 4), 32'h5555_5555, 4'hF, 1);
    send(32'hFFFF_FFFC, 32'h0, 4'h0, 0);
    send(32'h0, 32'h0, 4'h0, 0);
    drain();

    // back-pressure: only three requests fit with the response side stalled
    rsp_ready = 0;
    k = 0;
    for (int c = 0; c < 10; c++) begin
      if (k < 5) begin issue(32'(k * 4), 0, 0, 0, ok); if (ok) k++; end
      else tick();
    end
    check("bp_accepts", 32'(k), 32'd3);
    check("bp_ready_low", 32'(req_ready), 32'd0);
    rsp_ready = 1;
    while (k < 5) begin send(32'(k * 4), 0, 0, 0); k++; end
    drain();

    // streaming: 16 back-to-back reads
    n_ok = 0; first_fire = 0;
    for (int i = 0; i < 16; i++) begin
      issue(32'(i * 4), 0, 0, 0, ok);
      if (ok) begin n_ok++; if (n_ok == 1) first_fire = fire_cyc; end
    end
    drain();
    check("stream_accepts", 32'(n_ok), 32'd16);
    check("stream_span", 32'(rsp_cyc[rsp_cyc.size()-1] - rsp_cyc[rsp_cyc.size()-16]), 32'd15);
    check("stream_first", 32'(rsp_cyc[rsp_cyc.size()-16] - first_fire), 32'd2);

    // depth-2 instance: must throttle and lose nothing
    d2_valid = 1; acc = 0; streak = 0; maxs = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (d2_ready) begin acc++; streak++; if (streak > maxs) maxs = streak; end
      else streak = 0;
      @(posedge clk); #1;
    end
    d2_valid = 0;
    repeat (6) tick();
    check("d2_rsp_count", 32'(d2_rsp_n), 32'(acc));
    check("d2_throttle", 32'(maxs < 3 && acc < 30), 32'd1);
    check("d2_min_rate", 32'(acc >= 10), 32'd1);

    // randomized traffic with random response back-pressure
    rnd_done = 0;
    fork
      begin
        for (int i = 0; i < 150; i++) begin
          case ($urandom_range(0, 9))
            0, 1, 2, 3: send(32'($urandom_range(0, NW-1) * 4 + $urandom_range(0, 3)), 0, 0, 0);
            4, 5, 6, 7: send(32'($urandom_range(0, NW-1) * 4), $urandom, 4'($urandom_range(0, 15)), 1);
            8: begin
              a = 32'(MW * 4) + 32'($urandom_range(0, 4000) * 4);
              send(a, $urandom, 4'hF, $urandom_range(0, 1) == 1);
            end
            default: tick();
          endcase
        end
        rnd_done = 1;
      end
      begin
        while (!rnd_done) begin rsp_ready = ($urandom_range(0, 3) != 0); tick(); end
        rsp_ready = 1;
      end
    join
    drain();

    // reset with two responses pending
    rsp_ready = 0;
    send(32'h10, 0, 0, 0);
    send(32'h20, 0, 0, 0);
    tick();
    rst = 1;
    exp_q.delete();
    tick();
    rst = 0;
    @(negedge clk);
    check("rst_mid_valid", 32'(rsp_valid), 32'd0);
    @(posedge clk); #1;
    rsp_ready = 1;
    repeat (4) tick();
    send(32'h10, 0, 0, 0);
    send(32'h20, 0, 0, 0);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
